// File: rtl/corelet_seq.sv
// Compute tile: weight/activation L0 FIFO, MAC array, output FIFO and a psum buffer
// that accumulates across input-channel tiles, run by an on-block job sequencer.
module corelet_seq #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int depth   = 16,
   parameter int tile_w  = 6
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [tile_w-1:0]          cfg_tiles,
   input  logic [$clog2(depth):0]     cfg_len,
   input  logic                       relu_en,
   input  logic [row*bw-1:0]          in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [col*psum_bw-1:0]     out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       busy,
   output logic                       done,
   output logic                       cfg_err
);

   localparam int len_w = $clog2(depth) + 1;
   localparam int cnt_w = $clog2(col + row + depth) + 1;
   localparam int l0_aw = $clog2(col);
   localparam int of_aw = $clog2(depth);

   typedef enum logic [2:0] {IDLE, LOAD_W, KLOAD, EXEC, DRAIN, OUT, DONE} state_t;

   state_t state, state_next;

   logic [tile_w-1:0]  tiles_q, tile_cnt;
   logic [len_w-1:0]   len_q;
   logic               relu_q;
   logic [cnt_w-1:0]   vec_cnt, len_cnt, len_last;

   logic [row*bw-1:0]  l0_mem [col];
   logic [l0_aw-1:0]   l0_wr, l0_rd;
   logic [l0_aw:0]     l0_cnt;
   logic [row*bw-1:0]  wgt [col];

   logic [col*psum_bw-1:0] of_mem [depth];
   logic [of_aw-1:0]       of_wr, of_rd;
   logic [of_aw:0]         of_cnt;

   logic [col*psum_bw-1:0] psum [depth];
   logic [col*psum_bw-1:0] mac_out, drain_val;

   logic cfg_ok, start_ok, l0_full, l0_empty, of_full;
   logic in_fire, kload_pop, issue, l0_pop, of_pop, drain_last, out_fire, out_last;

   function automatic logic [psum_bw-1:0] dot(input logic [row*bw-1:0] act,
                                              input logic [row*bw-1:0] w);
      logic signed [psum_bw-1:0] acc, a, b;
      acc = '0;
      for (int i = 0; i < row; i++) begin
         a   = {{(psum_bw-bw){1'b0}}, act[i*bw +: bw]};
         b   = {{(psum_bw-bw){w[i*bw+bw-1]}}, w[i*bw +: bw]};
         acc = acc + a * b;
      end
      return acc;
   endfunction

   function automatic logic [psum_bw-1:0] sat_add(input logic [psum_bw-1:0] a,
                                                  input logic [psum_bw-1:0] b);
      logic [psum_bw:0] s;
      s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
      if (s[psum_bw] != s[psum_bw-1])
         return s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      return s[psum_bw-1:0];
   endfunction

   assign cfg_ok     = (cfg_tiles != '0) && (cfg_len != '0) && (cfg_len <= len_w'(depth));
   assign start_ok   = (state == IDLE) && start && cfg_ok;
   assign len_cnt    = cnt_w'(len_q);
   assign len_last   = len_cnt - cnt_w'(1);
   assign l0_full    = (l0_cnt == (l0_aw+1)'(col));
   assign l0_empty   = (l0_cnt == '0);
   assign of_full    = (of_cnt == (of_aw+1)'(depth));
   assign in_fire    = in_valid && in_ready;
   assign kload_pop  = (state == KLOAD) && (vec_cnt < cnt_w'(col));
   assign issue      = ((state == EXEC) || (state == DRAIN)) && !l0_empty && !of_full;
   assign l0_pop     = kload_pop || issue;
   assign of_pop     = (state == DRAIN) && (of_cnt != '0);
   assign drain_last = of_pop && (vec_cnt == len_last);
   assign out_fire   = out_valid && out_ready;
   assign out_last   = out_fire && (vec_cnt == len_last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_ok) state_next = LOAD_W;
         LOAD_W:  if (vec_cnt == cnt_w'(col)) state_next = KLOAD;
         KLOAD:   if (vec_cnt == cnt_w'(col + row - 2)) state_next = EXEC;
         EXEC:    if (vec_cnt == len_cnt) state_next = DRAIN;
         DRAIN:   if (drain_last)
                     state_next = (tile_cnt < tiles_q - tile_w'(1)) ? LOAD_W : OUT;
         OUT:     if (out_last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      logic [psum_bw-1:0] v;
      in_ready  = ((state == LOAD_W) && !l0_full && (vec_cnt < cnt_w'(col))) ||
                  ((state == EXEC) && !l0_full && !of_full && (vec_cnt < len_cnt));
      busy      = (state != IDLE);
      done      = (state == DONE);
      out_valid = (state == OUT);
      out_data  = '0;
      v         = '0;
      if (state == OUT) begin
         for (int c = 0; c < col; c++) begin
            v = psum[vec_cnt[of_aw-1:0]][c*psum_bw +: psum_bw];
            out_data[c*psum_bw +: psum_bw] = (relu_q && v[psum_bw-1]) ? '0 : v;
         end
      end
   end

   // One shared vector counter: it restarts on every state change and counts beats of that phase.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tiles_q  <= '0;
         len_q    <= '0;
         relu_q   <= 1'b0;
         tile_cnt <= '0;
         vec_cnt  <= '0;
         cfg_err  <= 1'b0;
      end else begin
         cfg_err <= (state == IDLE) && start && !cfg_ok;
         if (start_ok) begin
            tiles_q  <= cfg_tiles;
            len_q    <= cfg_len;
            relu_q   <= relu_en;
            tile_cnt <= '0;
         end else if (drain_last) begin
            tile_cnt <= tile_cnt + tile_w'(1);
         end
         if (state != state_next)
            vec_cnt <= '0;
         else if (in_fire || (state == KLOAD) || of_pop || out_fire)
            vec_cnt <= vec_cnt + cnt_w'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         l0_wr  <= '0;
         l0_rd  <= '0;
         l0_cnt <= '0;
         of_wr  <= '0;
         of_rd  <= '0;
         of_cnt <= '0;
      end else begin
         if (in_fire) l0_wr <= l0_wr + l0_aw'(1);
         if (l0_pop)  l0_rd <= l0_rd + l0_aw'(1);
         case ({in_fire, l0_pop})
            2'b10:   l0_cnt <= l0_cnt + (l0_aw+1)'(1);
            2'b01:   l0_cnt <= l0_cnt - (l0_aw+1)'(1);
            default: l0_cnt <= l0_cnt;
         endcase
         if (issue)  of_wr <= of_wr + of_aw'(1);
         if (of_pop) of_rd <= of_rd + of_aw'(1);
         case ({issue, of_pop})
            2'b10:   of_cnt <= of_cnt + (of_aw+1)'(1);
            2'b01:   of_cnt <= of_cnt - (of_aw+1)'(1);
            default: of_cnt <= of_cnt;
         endcase
      end
   end

   always_comb begin
      mac_out   = '0;
      drain_val = '0;
      for (int c = 0; c < col; c++) begin
         mac_out[c*psum_bw +: psum_bw] = dot(l0_mem[l0_rd], wgt[c]);
         drain_val[c*psum_bw +: psum_bw] = (tile_cnt == '0) ?
            of_mem[of_rd][c*psum_bw +: psum_bw] :
            sat_add(psum[vec_cnt[of_aw-1:0]][c*psum_bw +: psum_bw],
                    of_mem[of_rd][c*psum_bw +: psum_bw]);
      end
   end

   // Storage arrays carry no reset; every job reloads weights and tile 0 overwrites psum.
   always_ff @(posedge clk) begin
      if (in_fire)   l0_mem[l0_wr] <= in_data;
      if (kload_pop) wgt[vec_cnt[l0_aw-1:0]] <= l0_mem[l0_rd];
      if (issue)     of_mem[of_wr] <= mac_out;
      if (of_pop)    psum[vec_cnt[of_aw-1:0]] <= drain_val;
   end

endmodule

// File: tb/tb_corelet_seq.sv
// Directed bench for corelet_seq: single/multi-tile jobs, ReLU, saturation,
// backpressure with input gaps, config errors and reset in the middle of a job.
module tb_corelet_seq;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [5:0]   cfg_tiles = '0;
   logic [4:0]   cfg_len = '0;
   logic         relu_en = 1'b0;
   logic [31:0]  in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] out_data;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         busy, done, cfg_err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [3:0]  w_val;
   logic [3:0]  act_q [16];
   logic [15:0] exp_q [16];

   corelet_seq dut (
      .clk(clk), .reset(reset), .start(start), .cfg_tiles(cfg_tiles), .cfg_len(cfg_len),
      .relu_en(relu_en), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
      end
   endtask

   task automatic start_job(input int tiles, input int len, input bit relu);
      @(negedge clk);
      cfg_tiles = 6'(tiles);
      cfg_len   = 5'(len);
      relu_en   = relu;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   // Sends col weight beats then len activation beats, once per tile.
   task automatic feed(input int tiles, input int len, input bit gaps);
      int idx, total, cyc, pos;
      bit pend;
      total = tiles * (8 + len);
      idx = 0; cyc = 0; pend = 1'b0;
      while (idx < total && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (pend) idx++;
         pend = 1'b0;
         if (idx < total && !(gaps && $urandom_range(0, 3) == 0)) begin
            pos      = idx % (8 + len);
            in_data  = (pos < 8) ? {8{w_val}} : {8{act_q[pos-8]}};
            in_valid = 1'b1;
            pend     = in_ready;
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      check_output("feed_count", 128'(idx), 128'(total));
   endtask

   task automatic collect(input int len, input bit rnd, input string tag);
      int got, cyc;
      bit held, rdy;
      got = 0; cyc = 0; held = 1'b0;
      while (got < len && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (held) begin
            check_output({tag, "_hold_valid"}, 128'(out_valid), 128'd1);
            check_output({tag, "_hold_data"}, out_data, {8{exp_q[got]}});
         end
         if (out_valid) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            if (rdy) begin
               check_output({tag, "_result"}, out_data, {8{exp_q[got]}});
               got++;
               held = 1'b0;
            end else begin
               held = 1'b1;
            end
         end else begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            held = 1'b0;
         end
      end
      check_output({tag, "_count"}, 128'(got), 128'(len));
   endtask

   task automatic run_job(input int tiles, input int len, input bit relu,
                          input bit gaps, input bit rnd, input string tag);
      int dn;
      start_job(tiles, len, relu);
      fork
         feed(tiles, len, gaps);
         collect(len, rnd, tag);
      join
      dn = 0;
      repeat (3) begin
         @(negedge clk);
         out_ready = 1'b0;
         if (done) dn++;
      end
      check_output({tag, "_done_pulses"}, 128'(dn), 128'd1);
      check_output({tag, "_busy_after"}, 128'(busy), 128'd0);
   endtask

   task automatic bad_start(input int tiles, input int len, input string tag);
      @(negedge clk);
      cfg_tiles = 6'(tiles);
      cfg_len   = 5'(len);
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      check_output({tag, "_err"}, 128'(cfg_err), 128'd1);
      check_output({tag, "_busy"}, 128'(busy), 128'd0);
      @(negedge clk);
      check_output({tag, "_err_clear"}, 128'(cfg_err), 128'd0);
      check_output({tag, "_busy_idle"}, 128'(busy), 128'd0);
   endtask

   task automatic check_quiet(input string tag);
      check_output({tag, "_in_ready"}, 128'(in_ready), 128'd0);
      check_output({tag, "_out_valid"}, 128'(out_valid), 128'd0);
      check_output({tag, "_busy"}, 128'(busy), 128'd0);
      check_output({tag, "_done"}, 128'(done), 128'd0);
      check_output({tag, "_cfg_err"}, 128'(cfg_err), 128'd0);
      check_output({tag, "_out_data"}, out_data, 128'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_quiet("reset");
      reset = 1'b1;
      @(negedge clk);
      check_quiet("post_reset");

      // 8 ones times weight 1 -> 8; all-twos -> 16
      w_val = 4'd1; act_q[0] = 4'd1; act_q[1] = 4'd2;
      exp_q[0] = 16'd8; exp_q[1] = 16'd16;
      run_job(1, 2, 1'b0, 1'b0, 1'b0, "basic");

      // 3 tiles of 8*3 = 24 accumulate to 72
      w_val = 4'd1; act_q[0] = 4'd3; exp_q[0] = 16'd72;
      run_job(3, 1, 1'b0, 1'b0, 1'b0, "multi");

      w_val = 4'hF; act_q[0] = 4'd1; exp_q[0] = 16'hFFF8;
      run_job(1, 1, 1'b0, 1'b0, 1'b0, "neg");
      exp_q[0] = 16'd0;
      run_job(1, 1, 1'b1, 1'b0, 1'b0, "relu");

      // 40 tiles of 840 = 33600 clips at 32767
      w_val = 4'd7; act_q[0] = 4'd15; exp_q[0] = 16'd32767;
      run_job(40, 1, 1'b0, 1'b0, 1'b0, "sat");

      // vector k carries value k on every channel, weight 2 -> 16*k
      w_val = 4'd2;
      for (int k = 0; k < 16; k++) begin
         act_q[k] = 4'(k);
         exp_q[k] = 16'(16 * k);
      end
      run_job(1, 16, 1'b0, 1'b1, 1'b1, "bp");

      bad_start(1, 0, "len0");
      bad_start(1, 17, "len17");
      bad_start(0, 4, "tiles0");

      w_val = 4'd1;
      for (int k = 0; k < 4; k++) act_q[k] = 4'd1;
      start_job(1, 4, 1'b0);
      feed(1, 4, 1'b0);
      @(negedge clk);
      check_output("mid_busy", 128'(busy), 128'd1);
      reset = 1'b0;
      #1;
      check_quiet("mid_reset");
      @(negedge clk);
      reset = 1'b1;

      // 8*{5,0,15} with weight 1
      w_val = 4'd1; act_q[0] = 4'd5; act_q[1] = 4'd0; act_q[2] = 4'd15;
      exp_q[0] = 16'd40; exp_q[1] = 16'd0; exp_q[2] = 16'd120;
      run_job(1, 3, 1'b0, 1'b0, 1'b0, "after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
